shift_rows_pipe: RTL and testbench

Parametrised, pipelined Rijndael ShiftRows/InvShiftRows unit with ready/valid flow control. It supports block widths of 128, 192 and 256 bits (Nb = 4, 6, 8 columns), a per-transaction direction bit, and a configurable register depth. It carries a user tag alongside the data. It sits between SubBytes and MixColumns in the round datapath, and can stall under downstream backpressure without losing or duplicating blocks.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/shift_rows_stage.sv | 35 +++
 rtl/shift_rows_pipe.sv | 116 +++++++++++
 tb/tb_shift_rows_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and index helpers for the Rijndael round datapath.
//
// Contents:
//   NB_MIN / NB_MAX        range of legal state column counts (4, 6, 8)
//   nb_legal(nb)           1 when nb is one of 4, 6, 8
//   data_w(nb)             state width in bits (32 bits per column)
//   row_offset(nb, r)      ShiftRows rotation amount C_r for row r
//   fwd_src(nb, k)         ShiftRows: input byte index that lands at output byte k
//   inv_src(nb, k)         InvShiftRows: input byte index that lands at output byte k
//
// Byte k of a state sits at column k/4, row k%4, and byte 0 is the MSB.
package aes_pkg;

  localparam int NB_MIN = 4;
  localparam int NB_MAX = 8;

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  function automatic int data_w(input int nb);
    return 32 * nb;
  endfunction

  // The 256-bit block uses a larger skew on rows 2 and 3.
  function automatic int row_offset(input int nb, input int r);
    if (nb == 8) begin
      case (r)
        0:       return 0;
        1:       return 1;
        2:       return 3;
        default: return 4;
      endcase
    end
    return r;
  endfunction

  function automatic int fwd_src(input int nb, input int k);
    int c;
    int r;
    c = k / 4;
    r = k % 4;
    return 4 * ((c + row_offset(nb, r)) % nb) + r;
  endfunction

  function automatic int inv_src(input int nb, input int k);
    int c;
    int r;
    c = k / 4;
    r = k % 4;
    return 4 * ((c - row_offset(nb, r) + nb) % nb) + r;
  endfunction

endpackage

// File: rtl/shift_rows_stage.sv
// shift_rows_stage: one valid/data/tag register slot of the ShiftRows pipe.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset clears every field
//   load                slot captures d_* this cycle when high, holds otherwise
//   d_valid/d_data/d_tag  value offered by the upstream slot (or the input)
//   q_valid/q_data/q_tag  registered contents of this slot
module shift_rows_stage #(
  parameter int DATA_W = 128,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_data,
  input  logic [TAG_W-1:0]  d_tag,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [TAG_W-1:0]  q_tag
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_tag   <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      q_data  <= d_data;
      q_tag   <= d_tag;
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: pipelined Rijndael ShiftRows / InvShiftRows with a sideband tag.
//
// Parameters: NB (4, 6 or 8 columns), STAGES (1..4 register slots), TAG_W.
// Ports:
//   clk, reset                     clock; asynchronous active-low reset flushes the pipe
//   in_valid/in_ready              input handshake
//   in_inv                         1 selects InvShiftRows for this block
//   in_tag/in_data                 sideband tag and state for the offered block
//   out_valid/out_ready            output handshake
//   out_tag/out_data               tag and permuted state of the oldest block
//
// Build option: define SHIFT_ROWS_INV_EN to build the inverse permutation.
// Without it every block is forward ShiftRows and in_inv is ignored.
//
// Handshake: a block transfers on any edge where valid and ready are both high;
// valid, once raised, is held with stable data/tag until it transfers. Slot i
// loads whenever it is empty or slot i+1 is loading (or the consumer takes the
// output), so bubbles collapse and a full pipe can drain and fill in one cycle.
// in_ready is therefore combinational in out_ready; outputs come from registers.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4,
  localparam int DATA_W = data_w(NB)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data
);

  localparam int NBYTES = 4 * NB;

  // Permutation is pure wiring ahead of slot 0.
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] perm_data;

  for (genvar k = 0; k < NBYTES; k++) begin : g_fwd
    assign fwd_data[DATA_W-1-8*k -: 8] = in_data[DATA_W-1-8*fwd_src(NB, k) -: 8];
  end

`ifdef SHIFT_ROWS_INV_EN
  logic [DATA_W-1:0] inv_data;

  for (genvar k = 0; k < NBYTES; k++) begin : g_inv
    assign inv_data[DATA_W-1-8*k -: 8] = in_data[DATA_W-1-8*inv_src(NB, k) -: 8];
  end

  assign perm_data = in_inv ? inv_data : fwd_data;
`else
  logic unused_inv;

  assign unused_inv = in_inv;
  assign perm_data  = fwd_data;
`endif

  logic [STAGES-1:0] v;
  logic [STAGES:0]   rdy;
  logic [DATA_W-1:0] d_q [STAGES];
  logic [TAG_W-1:0]  t_q [STAGES];

  // Ready ripples back from the consumer through every slot that is occupied.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy[i] = !v[i] | rdy[i+1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [TAG_W-1:0]  s_tag;

    if (i == 0) begin : g_head
      assign s_valid = in_valid;
      assign s_data  = perm_data;
      assign s_tag   = in_tag;
    end else begin : g_body
      assign s_valid = v[i-1];
      assign s_data  = d_q[i-1];
      assign s_tag   = t_q[i-1];
    end

    shift_rows_stage #(
      .DATA_W(DATA_W),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .load   (rdy[i]),
      .d_valid(s_valid),
      .d_data (s_data),
      .d_tag  (s_tag),
      .q_valid(v[i]),
      .q_data (d_q[i]),
      .q_tag  (t_q[i])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign out_tag   = t_q[STAGES-1];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: self-checking bench for shift_rows_pipe.
// Three independent instances (NB/STAGES = 4/3, 8/2, 6/1), each with its own
// reset, driver, expected queue and monitor. Reference model rotates rows.
module tb_shift_rows_pipe;

`ifdef SHIFT_ROWS_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif
  localparam int N_INST = 3;

  function automatic int nb_of(input int g);
    case (g)
      0:       return 4;
      1:       return 8;
      default: return 6;
    endcase
  endfunction

  function automatic int st_of(input int g);
    case (g)
      0:       return 3;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fails  = 0;
  int n_done   = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fails++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Reference: split the state into 4 rows of nb bytes and rotate each row
  // left (forward) or right (inverse) by its offset, one byte at a time.
  function automatic logic [255:0] ref_rows(input int nb, input bit inv, input logic [255:0] d);
    logic [7:0]   row [8];
    logic [7:0]   tmp;
    logic [255:0] res;
    int           sh;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < nb; c++) row[c] = d[32*nb-1-8*(4*c+r) -: 8];
      sh = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int s = 0; s < sh; s++) begin
        if (!inv) begin
          tmp = row[0];
          for (int c = 0; c < nb - 1; c++) row[c] = row[c+1];
          row[nb-1] = tmp;
        end else begin
          tmp = row[nb-1];
          for (int c = nb - 1; c > 0; c--) row[c] = row[c-1];
          row[0] = tmp;
        end
      end
      for (int c = 0; c < nb; c++) res[32*nb-1-8*(4*c+r) -: 8] = row[c];
    end
    return res;
  endfunction

  for (genvar g = 0; g < N_INST; g++) begin : g_inst
    localparam int NBV = nb_of(g);
    localparam int ST  = st_of(g);
    localparam int W   = 32 * NBV;

    logic         rst;
    logic         iv;
    logic         ir;
    logic         inv;
    logic         ov;
    logic         ordy;
    logic [3:0]   it;
    logic [3:0]   ot;
    logic [W-1:0] id;
    logic [W-1:0] od;

    logic [W+3:0] exp_q[$];
    int           acc_q[$];
    int           cyc = 0;
    bit           lat_chk = 1'b0;
    bit           prev_stall = 1'b0;
    bit           done_r = 1'b0;
    logic [W+3:0] prev_out;

    shift_rows_pipe #(
      .NB    (NBV),
      .STAGES(ST),
      .TAG_W (4)
    ) u_dut (
      .clk      (clk),
      .reset    (rst),
      .in_valid (iv),
      .in_ready (ir),
      .in_inv   (inv),
      .in_tag   (it),
      .in_data  (id),
      .out_valid(ov),
      .out_ready(ordy),
      .out_tag  (ot),
      .out_data (od)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input bit iinv);
      logic [255:0] r;
      r = ref_rows(NBV, iinv & INV_EN, 256'(d));
      return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_block();
      logic [W-1:0] d;
      for (int j = 0; j < NBV; j++) d[32*j +: 32] = $urandom();
      return d;
    endfunction

    // ---------------- monitor: samples 1 time unit before each rising edge ----------------
    always begin
      logic [W+3:0] e;
      int           a;
      @(negedge clk);
      #4;
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check($sformatf("i%0d stall valid", g), 256'(ov), 256'(1));
          check($sformatf("i%0d stall hold", g), 256'({ot, od}), 256'(prev_out));
        end
        if (ov && ordy) begin
          if (exp_q.size() == 0) begin
            fail_now($sformatf("i%0d unexpected output", g));
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check($sformatf("i%0d out block", g), 256'({ot, od}), 256'(e));
            if (lat_chk) check($sformatf("i%0d latency", g), 256'(cyc + 1 - a), 256'(ST));
          end
        end
        prev_stall = ov && !ordy;
        prev_out   = {ot, od};
      end
    end

    // ---------------- driver tasks (called at a falling edge, return at one) ----------------
    task automatic send(input logic [W-1:0] d, input logic [3:0] t, input logic iinv,
                        input logic [W-1:0] e);
      bit acc;
      int n;
      iv  = 1'b1;
      id  = d;
      it  = t;
      inv = iinv;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
        #4;
        acc = ir;
        if (acc) begin
          exp_q.push_back({t, e});
          acc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        n++;
      end
      iv = 1'b0;
      if (!acc) fail_now($sformatf("i%0d send timeout", g));
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) fail_now($sformatf("i%0d drain timeout", g));
      @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
      logic [W-1:0]   d;
      logic [W-1:0]   e;
      logic [W-1:0]   f;
      logic [255:0]   lit;
      int             acc_n;
      rst = 1'b0; iv = 1'b0; inv = 1'b0; it = '0; id = '0; ordy = 1'b1;
      repeat (2) @(negedge clk);
      check($sformatf("i%0d reset out_valid", g), 256'(ov), 256'(0));
      check($sformatf("i%0d reset out_data", g), 256'(od), 256'(0));
      check($sformatf("i%0d reset out_tag", g), 256'(ot), 256'(0));
      rst = 1'b1;
      #1;
      check($sformatf("i%0d in_ready after reset", g), 256'(ir), 256'(1));
      @(negedge clk);

      // Directed: bytes 0,1,2,... forward, then the forward result inverted.
      for (int k = 0; k < 4 * NBV; k++) d[W-1-8*k -: 8] = 8'(k);
      lit = 256'h000102030405060708090a0b0c0d0e0f;
      lit = (NBV == 4) ? 256'h00050a0f04090e03080d02070c01060b : 256'(model(d, 1'b0));
      e = lit[W-1:0];
      send(d, 4'ha, 1'b0, e);
      lit = INV_EN ? 256'h000d0a0704010e0b0805020f0c090603 : 256'h00050a0f04090e03080d02070c01060b;
      lit = (NBV == 4) ? lit : 256'(model(d, 1'b1));
      e = lit[W-1:0];
      send(d, 4'h5, 1'b1, e);
      f = model(d, 1'b0);
      e = INV_EN ? d : model(f, 1'b0);
      send(f, 4'h3, 1'b1, e);
      drain();

      // Back-to-back stream with the consumer always ready: fixed latency.
      lat_chk = 1'b1;
      for (int b = 0; b < 10; b++) begin
        d = rand_block();
        send(d, 4'(b), 1'b0, model(d, 1'b0));
      end
      drain();
      lat_chk = 1'b0;

      // Backpressure: consumer stalls 5 cycles; only STAGES blocks fit.
      ordy  = 1'b0;
      acc_n = 0;
      d     = rand_block();
      iv = 1'b1; id = d; it = 4'(acc_n); inv = 1'b0;
      for (int c = 0; c < 5; c++) begin
        #4;
        if (ir) begin
          exp_q.push_back({4'(acc_n), model(d, 1'b0)});
          acc_q.push_back(cyc + 1);
          acc_n++;
          d = rand_block();
        end
        @(negedge clk);
        id = d;
        it = 4'(acc_n);
      end
      #4;
      check($sformatf("i%0d bp in_ready low", g), 256'(ir), 256'(0));
      @(negedge clk);
      iv = 1'b0;
      check($sformatf("i%0d bp accepts", g), 256'(acc_n), 256'(ST));
      ordy = 1'b1;
      drain();

      // Reset with blocks in flight: everything flushed immediately.
      ordy = 1'b0;
      for (int b = 0; b < 2 && b < ST; b++) begin
        d = rand_block();
        send(d, 4'hf, 1'b0, model(d, 1'b0));
      end
      #2;
      rst = 1'b0;
      #1;
      check($sformatf("i%0d flush out_valid", g), 256'(ov), 256'(0));
      check($sformatf("i%0d flush out_data", g), 256'(od), 256'(0));
      check($sformatf("i%0d flush out_tag", g), 256'(ot), 256'(0));
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      rst  = 1'b1;
      ordy = 1'b1;
      #1;
      check($sformatf("i%0d in_ready after flush", g), 256'(ir), 256'(1));
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        #4;
        check($sformatf("i%0d no stale block", g), 256'(ov), 256'(0));
      end
      @(negedge clk);

      // Random traffic with random gaps, directions and consumer stalls.
      fork
        begin
          for (int b = 0; b < 150; b++) begin
            logic rinv;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            d    = rand_block();
            rinv = 1'($urandom_range(0, 1));
            send(d, 4'($urandom_range(0, 15)), rinv, model(d, rinv));
          end
          done_r = 1'b1;
        end
        begin
          while (!done_r) begin
            ordy = ($urandom_range(0, 2) != 0);
            @(negedge clk);
          end
          ordy = 1'b1;
        end
      join
      drain();
      n_done++;
    end
  end

  // ---------------- final report ----------------
  initial begin
    for (int t = 0; t < 50000 && n_done < N_INST; t++) @(posedge clk);
    if (n_done < N_INST) fail_now("global timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
